// File: rtl/fifo_disp_pkg.sv
// Shared constants and helpers for the FIFO display monitor.
//   SEG_*        7-segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   bcd_state_e  states of the sequential binary-to-BCD converter
//   bcd_digits   decimal digits needed to show 2**width-1
//   pow10        10**n, used for the display-size elaboration check
//   seg_of       BCD digit to segment pattern
package fifo_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_e;

  // floor(width*log10(2)) + 1, with log10(2) approximated as 0.301
  function automatic int bcd_digits(input int width);
    return (width * 32'sd301) / 32'sd1000 + 32'sd1;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
//   clk, reset  system clock, synchronous active-high reset
//   btn         raw asynchronous, bouncy button
//   pulse       one-cycle pulse when a press (0->1) is accepted
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  import fifo_disp_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          pulse_r;
  logic [CW-1:0] cnt_r;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Counts consecutive samples differing from the accepted level; any
  // sample matching the accepted level restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CW'(DEBOUNCE_CYC - 1)) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
        pulse_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/fifo_display_monitor.sv
// FIFO demo top: debounced write/read buttons drive a first-word-fall-through
// FIFO; the head value or occupancy is converted to BCD and scanned onto a
// multiplexed 7-segment display. Sticky overflow/underflow flags.
//   clk, reset   system clock, synchronous active-high reset
//   wr_btn       raw write button        rd_btn    raw read button
//   clr_err      clears error flags      disp_mode 0 = head data, 1 = count
//   data_in      write data              data_in_out combinational echo
//   seg_out      {g,f,e,d,c,b,a} active-high
//   dig_en_n     active-low digit enables, at most one low
//   full, empty  FIFO status             overflow, underflow sticky errors
module fifo_display_monitor
  import fifo_disp_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 200000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_btn,
  input  logic                  rd_btn,
  input  logic                  clr_err,
  input  logic                  disp_mode,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_in_out,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en_n,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SRC_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;
  localparam int NBCD  = bcd_digits(SRC_W);
  localparam int BCD_W = 4 * NBCD;
  localparam int BC_W  = $clog2(SRC_W + 1);
  localparam int RF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned MAX_DATA = (64'd1 << DATA_W) - 64'd1;
  localparam longint unsigned MAX_SHOW =
    (MAX_DATA > longint'(DEPTH)) ? MAX_DATA : longint'(DEPTH);

  if (pow10(NUM_DIGITS) <= MAX_SHOW) begin : g_bad_digits
    $error("NUM_DIGITS too small for the largest displayable value");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  // ---------------- buttons ----------------
  logic wr_pulse_s;
  logic rd_pulse_s;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_wr_db (
    .clk(clk), .reset(reset), .btn(wr_btn), .pulse(wr_pulse_s)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rd_db (
    .clk(clk), .reset(reset), .btn(rd_btn), .pulse(rd_pulse_s)
  );

  assign data_in_out = data_in;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              do_wr_s;
  logic              do_rd_s;
  logic              ovf_set_s;
  logic              udf_set_s;
  logic [DATA_W-1:0] head_s;

  // Accepted operations; a write on a full FIFO proceeds only when a pop
  // frees the slot in the same cycle
  always_comb begin
    do_rd_s     = rd_pulse_s & ~empty_r;
    do_wr_s     = wr_pulse_s & (~full_r | do_rd_s);
    ovf_set_s   = wr_pulse_s & full_r & ~rd_pulse_s;
    udf_set_s   = rd_pulse_s & empty_r;
    count_nxt_s = count_r + CNT_W'(do_wr_s) - CNT_W'(do_rd_s);
    if (empty_r) begin
      head_s = {DATA_W{1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  // Storage array, no reset needed: contents are only visible when !empty
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (udf_set_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // ---------------- binary to BCD ----------------
  logic [SRC_W-1:0] src_s;
  logic [SRC_W-1:0] latched_r;
  logic [SRC_W-1:0] last_src_r;
  logic [SRC_W-1:0] shreg_r;
  logic [BCD_W-1:0] bcd_acc_r;
  logic [BCD_W-1:0] acc_adj_s;
  logic [BCD_W-1:0] bcd_disp_r;
  logic [BC_W-1:0]  bit_cnt_r;
  bcd_state_e       bcd_state_r;
  bcd_state_e       bcd_next_s;

  assign src_s = disp_mode ? SRC_W'(count_r) : SRC_W'(head_s);

  // Add-3 correction on every BCD nibble that is 5 or more before each shift
  always_comb begin
    acc_adj_s = bcd_acc_r;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_acc_r[4*i +: 4] >= 4'd5) begin
        acc_adj_s[4*i +: 4] = bcd_acc_r[4*i +: 4] + 4'd3;
      end else begin
        acc_adj_s[4*i +: 4] = bcd_acc_r[4*i +: 4];
      end
    end
  end

  // Converter next-state logic
  always_comb begin
    bcd_next_s = bcd_state_r;
    case (bcd_state_r)
      BCD_IDLE: begin
        if (src_s != last_src_r) begin
          bcd_next_s = BCD_SHIFT;
        end else begin
          bcd_next_s = BCD_IDLE;
        end
      end
      BCD_SHIFT: begin
        if (bit_cnt_r == BC_W'(SRC_W - 1)) begin
          bcd_next_s = BCD_DONE;
        end else begin
          bcd_next_s = BCD_SHIFT;
        end
      end
      BCD_DONE: bcd_next_s = BCD_IDLE;
      default:  bcd_next_s = BCD_IDLE;
    endcase
  end

  // Converter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_state_r <= BCD_IDLE;
    end else begin
      bcd_state_r <= bcd_next_s;
    end
  end

  // Converter datapath: latch in IDLE, shift SRC_W bits, publish in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      latched_r  <= {SRC_W{1'b0}};
      last_src_r <= {SRC_W{1'b0}};
      shreg_r    <= {SRC_W{1'b0}};
      bcd_acc_r  <= {BCD_W{1'b0}};
      bcd_disp_r <= {BCD_W{1'b0}};
      bit_cnt_r  <= {BC_W{1'b0}};
    end else begin
      case (bcd_state_r)
        BCD_IDLE: begin
          if (src_s != last_src_r) begin
            latched_r <= src_s;
            shreg_r   <= src_s;
            bcd_acc_r <= {BCD_W{1'b0}};
            bit_cnt_r <= {BC_W{1'b0}};
          end
        end
        BCD_SHIFT: begin
          bcd_acc_r <= {acc_adj_s[BCD_W-2:0], shreg_r[SRC_W-1]};
          shreg_r   <= shreg_r << 1;
          bit_cnt_r <= bit_cnt_r + BC_W'(1'b1);
        end
        BCD_DONE: begin
          bcd_disp_r <= bcd_acc_r;
          last_src_r <= latched_r;
        end
        default: begin
          bit_cnt_r <= {BC_W{1'b0}};
        end
      endcase
    end
  end

  // ---------------- display scan ----------------
  logic [RF_W-1:0]       refresh_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BCD_W-1:0]      shifted_s;
  logic [3:0]            digit_s;
  logic [6:0]            seg_next_s;
  logic [NUM_DIGITS-1:0] dig_next_s;
  logic [6:0]            seg_out_r;
  logic [NUM_DIGITS-1:0] dig_en_n_r;

  // Digit pattern for the current slot; a digit is blanked when it and
  // every digit above it are zero, except the units digit
  always_comb begin
    shifted_s = bcd_disp_r >> {idx_r, 2'b00};
    digit_s   = shifted_s[3:0];
    if (!disp_mode && empty_r) begin
      seg_next_s = SEG_DASH;
    end else if ((idx_r == {IDX_W{1'b0}}) || (shifted_s != {BCD_W{1'b0}})) begin
      seg_next_s = seg_of(digit_s);
    end else begin
      seg_next_s = SEG_BLANK;
    end
    dig_next_s = ~(NUM_DIGITS'(1'b1) << idx_r);
  end

  // Refresh timer, digit index and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_r <= {RF_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      seg_out_r     <= SEG_BLANK;
      dig_en_n_r    <= {NUM_DIGITS{1'b1}};
    end else begin
      if (refresh_cnt_r == RF_W'(REFRESH_DIV - 1)) begin
        refresh_cnt_r <= {RF_W{1'b0}};
        if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1'b1);
        end
      end else begin
        refresh_cnt_r <= refresh_cnt_r + RF_W'(1'b1);
      end
      seg_out_r  <= seg_next_s;
      dig_en_n_r <= dig_next_s;
    end
  end

  assign seg_out  = seg_out_r;
  assign dig_en_n = dig_en_n_r;

endmodule

// File: tb/tb_fifo_display_monitor.sv
module tb_fifo_display_monitor;
  import fifo_disp_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ND     = 3;
  localparam int RDIV   = 8;
  localparam int DEB    = 4;
  localparam int SRC_W  = 8;
  localparam logic [6:0] TBL [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                      7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  logic              clk = 1'b0;
  logic              reset, wr_btn, rd_btn, clr_err, disp_mode;
  logic [DATA_W-1:0] data_in, data_in_out;
  logic [6:0]        seg_out;
  logic [ND-1:0]     dig_en_n;
  logic              full, empty, overflow, underflow;

  fifo_display_monitor #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_DIGITS(ND),
    .REFRESH_DIV(RDIV), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .reset(reset), .wr_btn(wr_btn), .rd_btn(rd_btn),
    .clr_err(clr_err), .disp_mode(disp_mode), .data_in(data_in),
    .data_in_out(data_in_out), .seg_out(seg_out), .dig_en_n(dig_en_n),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit dash;
  } exp_t;

  exp_t exp_q[$];
  int   mdl_q[$];
  bit   m_ovf, m_udf;
  int   n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input exp_t e, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (e.dash) return 7'h40;
    if (d == 0 || e.val >= p) return TBL[(e.val / p) % 10];
    return 7'h00;
  endfunction

  // Pops the next expected display and captures one full scan period
  task automatic check_display(input string tag);
    exp_t       e;
    logic [6:0] seen [ND];
    bit         got [ND];
    bit         bad;
    int         lows, k;
    e = exp_q.pop_front();
    bad = 1'b0;
    for (int d = 0; d < ND; d++) begin seen[d] = 7'h00; got[d] = 1'b0; end
    for (int c = 0; c < ND * RDIV + 4; c++) begin
      @(negedge clk);
      lows = 0; k = 0;
      for (int d = 0; d < ND; d++) if (!dig_en_n[d]) begin lows++; k = d; end
      if (lows > 1) bad = 1'b1;
      if (lows == 1) begin seen[k] = seg_out; got[k] = 1'b1; end
    end
    chk({tag, "_onehot"}, {31'd0, bad}, 32'd0);
    for (int d = 0; d < ND; d++)
      chk($sformatf("%s_d%0d", tag, d), got[d] ? {25'd0, seen[d]} : 32'hffff_ffff,
          {25'd0, exp_seg(e, d)});
  endtask

  // Press buttons, update the model, check status and the displayed head
  task automatic step(input string tag, input bit w, input bit r, input int d);
    bit do_rd, do_wr, was_full, was_empty;
    was_full  = (mdl_q.size() == DEPTH);
    was_empty = (mdl_q.size() == 0);
    do_rd = r && !was_empty;
    do_wr = w && (!was_full || do_rd);
    if (w && was_full && !r) m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
    if (do_rd) void'(mdl_q.pop_front());
    if (do_wr) mdl_q.push_back(d);
    data_in = d[7:0];
    wr_btn = w; rd_btn = r;
    repeat (10) @(negedge clk);
    wr_btn = 1'b0; rd_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, 32'(dut.count_r), mdl_q.size());
    chk({tag, "_full"}, {31'd0, full}, {31'd0, mdl_q.size() == DEPTH});
    chk({tag, "_empty"}, {31'd0, empty}, {31'd0, mdl_q.size() == 0});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, "_udf"}, {31'd0, underflow}, {31'd0, m_udf});
    exp_q.push_back('{val: (mdl_q.size() > 0) ? mdl_q[0] : 0, dash: mdl_q.size() == 0});
    repeat (SRC_W + 3) @(negedge clk);
    check_display(tag);
  endtask

  task automatic clear_err(input string tag);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_udf"}, {31'd0, underflow}, 32'd0);
  endtask

  task automatic latency(input string tag, input logic [11:0] want);
    int cyc;
    cyc = 0;
    while (dut.bcd_disp_r !== want && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_bcd"}, 32'(dut.bcd_disp_r), 32'(want));
    chk({tag, "_cycles"}, cyc, SRC_W + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; m_ovf = 1'b0; m_udf = 1'b0;
    reset = 1'b1; wr_btn = 1'b0; rd_btn = 1'b0; clr_err = 1'b0;
    disp_mode = 1'b0; data_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_dig", {29'd0, dig_en_n}, 32'h7);
    chk("rst_seg", {25'd0, seg_out}, 32'h0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_udf", {31'd0, underflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("slot0_dig", {29'd0, dig_en_n}, 32'h6);
    chk("slot0_seg", {25'd0, seg_out}, 32'h40);

    // bouncing write button, then held
    data_in = 8'd205;
    for (int i = 0; i < 3; i++) begin
      wr_btn = 1'b1; repeat (2) @(negedge clk);
      wr_btn = 1'b0; repeat (2) @(negedge clk);
    end
    chk("bounce_none", 32'(dut.count_r), 32'd0);
    wr_btn = 1'b1; repeat (20) @(negedge clk);
    wr_btn = 1'b0; repeat (10) @(negedge clk);
    mdl_q.push_back(205);
    chk("bounce_count", 32'(dut.count_r), 32'd1);
    chk("echo", {24'd0, data_in_out}, 32'd205);
    exp_q.push_back('{val: 205, dash: 1'b0});
    check_display("head205");

    disp_mode = 1'b1;
    latency("lat_mode1", 12'h001);
    exp_q.push_back('{val: 1, dash: 1'b0});
    check_display("count1");
    @(negedge clk);
    disp_mode = 1'b0;
    latency("lat_mode0", 12'h205);
    @(negedge clk);

    step("w2", 1'b1, 1'b0, 11);
    step("w3", 1'b1, 1'b0, 99);
    step("w4", 1'b1, 1'b0, 7);
    step("w5_ovf", 1'b1, 1'b0, 55);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_err("clr1");

    step("wr_rd_full", 1'b1, 1'b1, 123);
    step("rd1", 1'b0, 1'b1, 0);
    step("rd2", 1'b0, 1'b1, 0);
    step("rd3", 1'b0, 1'b1, 0);
    step("rd4", 1'b0, 1'b1, 0);
    step("rd_empty", 1'b0, 1'b1, 0);
    clear_err("clr2");
    step("wr_rd_empty", 1'b1, 1'b1, 77);

    // reset in the middle of a conversion
    disp_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shift", 32'(dut.bcd_state_r), 32'(BCD_SHIFT));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_state", 32'(dut.bcd_state_r), 32'(BCD_IDLE));
    chk("mr_bcd", 32'(dut.bcd_disp_r), 32'd0);
    chk("mr_count", 32'(dut.count_r), 32'd0);
    chk("mr_dig", {29'd0, dig_en_n}, 32'h7);
    chk("mr_seg", {25'd0, seg_out}, 32'h0);
    chk("mr_full", {31'd0, full}, 32'd0);
    chk("mr_empty", {31'd0, empty}, 32'd1);
    chk("mr_ovf", {31'd0, overflow}, 32'd0);
    chk("mr_udf", {31'd0, underflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
